// File: rtl/register_sequencer.sv
// rtl/register_sequencer.sv - in-order register bus sequencer with command FIFO and bus timeout
module register_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_rw,
    input  logic [31:0] i_cmd_address,
    input  logic [31:0] i_cmd_wdata,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ready,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_timeout,
    output logic        o_busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [PW:0]   DEPTH_L   = (PW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMEOUT_L = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQUEST = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic          fifo_rw_q   [FIFO_DEPTH];
    logic [31:0]   fifo_addr_q [FIFO_DEPTH];
    logic [31:0]   fifo_wdata_q[FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          fifo_push, fifo_pop, fifo_empty;

    logic          bus_request_q, bus_request_d;
    logic          bus_rw_q, bus_rw_d;
    logic [31:0]   bus_address_q, bus_address_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0]   res_data_q, res_data_d;
    logic          res_timeout_q, res_timeout_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_timeout_q, rsp_timeout_d;

    assign fifo_empty  = (count_q == '0);
    assign o_cmd_ready = (count_q != DEPTH_L);
    assign fifo_push   = i_cmd_valid && o_cmd_ready;
    assign fifo_pop    = (state_q == S_IDLE) && !fifo_empty;

    // Storage is not reset; occupancy and pointers alone define validity.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fifo_push) begin
                fifo_rw_q[wr_ptr_q]    <= i_cmd_rw;
                fifo_addr_q[wr_ptr_q]  <= i_cmd_address;
                fifo_wdata_q[wr_ptr_q] <= i_cmd_wdata;
                wr_ptr_q               <= wr_ptr_q + PW'(1);
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + (PW + 1)'(fifo_push) - (PW + 1)'(fifo_pop);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= S_IDLE;
            bus_request_q <= 1'b0;
            bus_rw_q      <= 1'b0;
            bus_address_q <= '0;
            bus_wdata_q   <= '0;
            timer_q       <= '0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus_request_q <= bus_request_d;
            bus_rw_q      <= bus_rw_d;
            bus_address_q <= bus_address_d;
            bus_wdata_q   <= bus_wdata_d;
            timer_q       <= timer_d;
            res_data_q    <= res_data_d;
            res_timeout_q <= res_timeout_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (!fifo_empty) state_d = S_REQUEST;
            S_REQUEST: if (i_bus_ready || timer_q == TIMEOUT_L) state_d = S_RESPOND;
            S_RESPOND: if (!rsp_valid_q || i_rsp_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus_request_d = bus_request_q;
        bus_rw_d      = bus_rw_q;
        bus_address_d = bus_address_q;
        bus_wdata_d   = bus_wdata_q;
        timer_d       = timer_q;
        res_data_d    = res_data_q;
        res_timeout_d = res_timeout_q;
        rsp_valid_d   = rsp_valid_q && !i_rsp_ready;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    bus_request_d = 1'b1;
                    bus_rw_d      = fifo_rw_q[rd_ptr_q];
                    bus_address_d = fifo_addr_q[rd_ptr_q];
                    bus_wdata_d   = fifo_wdata_q[rd_ptr_q];
                    timer_d       = '0;
                end
            end
            S_REQUEST: begin
                // Ready wins over an expiring timer on the same edge.
                if (i_bus_ready) begin
                    bus_request_d = 1'b0;
                    res_data_d    = bus_rw_q ? 32'h0 : i_bus_rdata;
                    res_timeout_d = 1'b0;
                end else if (timer_q == TIMEOUT_L) begin
                    bus_request_d = 1'b0;
                    res_data_d    = 32'h0;
                    res_timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RESPOND: begin
                if (!rsp_valid_q || i_rsp_ready) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = res_data_q;
                    rsp_timeout_d = res_timeout_q;
                end
            end
            default: begin
                bus_request_d = 1'b0;
            end
        endcase
    end

    assign o_bus_request = bus_request_q;
    assign o_bus_rw      = bus_rw_q;
    assign o_bus_address = bus_address_q;
    assign o_bus_wdata   = bus_wdata_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_timeout = rsp_timeout_q;
    assign o_busy        = (state_q != S_IDLE) || !fifo_empty || rsp_valid_q;

endmodule

// File: tb/tb_register_sequencer.sv
// tb/tb_register_sequencer.sv - directed and random stimulus against a memory-backed reference model
module tb_register_sequencer;
    localparam int TO    = 8;
    localparam int DEPTH = 4;

    logic        i_clock, i_reset;
    logic        i_cmd_valid, o_cmd_ready, i_cmd_rw;
    logic [31:0] i_cmd_address, i_cmd_wdata;
    logic        o_bus_request, o_bus_rw;
    logic [31:0] o_bus_address, o_bus_wdata, i_bus_rdata;
    logic        i_bus_ready;
    logic        o_rsp_valid, i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_timeout, o_busy;

    register_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_rw(i_cmd_rw),
        .i_cmd_address(i_cmd_address), .i_cmd_wdata(i_cmd_wdata),
        .o_bus_request(o_bus_request), .o_bus_rw(o_bus_rw), .o_bus_address(o_bus_address),
        .o_bus_wdata(o_bus_wdata), .i_bus_rdata(i_bus_rdata), .i_bus_ready(i_bus_ready),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_timeout(o_rsp_timeout), .o_busy(o_busy)
    );

    typedef struct { logic rw; logic [31:0] addr; logic [31:0] wdata; int high; int gap; } bus_rec_t;
    typedef struct { logic rw; logic [31:0] addr; logic [31:0] wdata; int high; logic to; logic [31:0] rdata; } exp_t;
    typedef struct { logic to; logic [31:0] rdata; } rsp_t;

    bus_rec_t    bus_q[$];
    exp_t        exp_q[$];
    rsp_t        act_q[$];
    int          dly_q[$];
    logic [31:0] dev_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int          tests_run = 0;
    int          tests_failed = 0;
    bit          full_seen;

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Bus responder: asserts ready dly+1 cycles into each request and logs every transaction.
    initial begin
        int cyc, low, cur;
        bus_rec_t r;
        i_bus_ready = 1'b0; i_bus_rdata = '0;
        cyc = 0; low = 100; cur = 1000;
        forever begin
            @(posedge i_clock); #1;
            if (o_bus_request) begin
                if (cyc == 0) begin
                    cur = (dly_q.size() > 0) ? dly_q.pop_front() : 1000;
                    r.rw = o_bus_rw; r.addr = o_bus_address; r.wdata = o_bus_wdata; r.gap = low;
                end
                cyc++;
            end else begin
                if (cyc > 0) begin
                    r.high = cyc;
                    bus_q.push_back(r);
                    low = 0;
                end
                cyc = 0;
                low++;
            end
            if (o_bus_request && cyc == cur + 1) begin
                i_bus_ready = 1'b1;
                if (o_bus_rw) begin
                    dev_mem[o_bus_address] = o_bus_wdata;
                    i_bus_rdata = $urandom;
                end else begin
                    i_bus_rdata = dev_mem.exists(o_bus_address) ? dev_mem[o_bus_address] : 32'h0;
                end
            end else begin
                i_bus_ready = 1'b0;
                i_bus_rdata = $urandom;
            end
        end
    end

    initial begin
        rsp_t r;
        forever begin
            @(negedge i_clock);
            if (!i_reset && o_rsp_valid && i_rsp_ready) begin
                r.to = o_rsp_timeout; r.rdata = o_rsp_rdata;
                act_q.push_back(r);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock); #2;
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // Model: a transaction succeeds iff the responder answers no later than the TIMEOUT-th timer value.
    task automatic push(input logic rw, input logic [31:0] addr, input logic [31:0] wdata, input int dly);
        int n;
        exp_t e;
        i_cmd_valid = 1'b1; i_cmd_rw = rw; i_cmd_address = addr; i_cmd_wdata = wdata;
        n = 0;
        while (!o_cmd_ready && n < 100) begin
            full_seen = 1'b1;
            tick();
            n++;
        end
        if (n >= 100) check("push_bound", 32'(n), 32'(0));
        tick();
        i_cmd_valid = 1'b0;
        dly_q.push_back(dly);
        e.rw = rw; e.addr = addr; e.wdata = wdata;
        e.high = ((dly < TO) ? dly : TO) + 1;
        if (dly <= TO) begin
            e.to = 1'b0;
            if (rw) begin
                ref_mem[addr] = wdata;
                e.rdata = 32'h0;
            end else begin
                e.rdata = ref_rd(addr);
            end
        end else begin
            e.to = 1'b1; e.rdata = 32'h0;
        end
        exp_q.push_back(e);
    endtask

    task automatic drain(input int n, input bit rand_ready);
        int cyc;
        exp_t e;
        rsp_t a;
        bus_rec_t b;
        cyc = 0;
        while (act_q.size() < n && cyc < 3000) begin
            i_rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            cyc++;
        end
        i_rsp_ready = 1'b1;
        check("drain_count", 32'(act_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0 || act_q.size() == 0 || bus_q.size() == 0) begin
                check("drain_queues", 32'(bus_q.size() > 0 && act_q.size() > 0), 32'(exp_q.size() > 0));
                break;
            end
            e = exp_q.pop_front(); a = act_q.pop_front(); b = bus_q.pop_front();
            check("rsp_rdata", a.rdata, e.rdata);
            check("rsp_timeout", 32'(a.to), 32'(e.to));
            check("bus_rw", 32'(b.rw), 32'(e.rw));
            check("bus_addr", b.addr, e.addr);
            check("bus_wdata", b.wdata, e.wdata);
            check("bus_high", 32'(b.high), 32'(e.high));
            check("bus_gap_ge2", 32'(b.gap >= 2), 32'(1));
        end
    endtask

    initial begin
        i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd_rw = 1'b0; i_cmd_address = '0; i_cmd_wdata = '0;
        i_rsp_ready = 1'b1; full_seen = 1'b0;
        dev_mem[32'h3] = 32'hDEADBEEF;
        ref_mem[32'h3] = 32'hDEADBEEF;
        repeat (3) tick();
        i_reset = 1'b0;
        check("rst_request", 32'(o_bus_request), 32'(0));
        check("rst_rsp_valid", 32'(o_rsp_valid), 32'(0));
        check("rst_rsp_timeout", 32'(o_rsp_timeout), 32'(0));
        check("rst_rsp_rdata", o_rsp_rdata, 32'h0);
        check("rst_bus_rw", 32'(o_bus_rw), 32'(0));
        check("rst_bus_addr", o_bus_address, 32'h0);
        check("rst_bus_wdata", o_bus_wdata, 32'h0);
        check("rst_busy", 32'(o_busy), 32'(0));
        check("rst_cmd_ready", 32'(o_cmd_ready), 32'(1));
        tick();

        // Single read with request-rise latency
        push(1'b0, 32'h3, 32'h0, 1);
        check("req_lat_early", 32'(o_bus_request), 32'(0));
        tick();
        check("req_lat_rise", 32'(o_bus_request), 32'(1));
        drain(1, 1'b0);

        // Write then read back
        push(1'b1, 32'h1, 32'hA5, 1);
        push(1'b0, 32'h1, 32'h0, 1);
        drain(2, 1'b0);

        // Silent responder times out, next command recovers
        push(1'b0, 32'h5, 32'h0, 1000);
        drain(1, 1'b0);
        push(1'b0, 32'h3, 32'h0, 1);
        drain(1, 1'b0);

        // Ready on the same cycle the timer reaches TIMEOUT
        push(1'b0, 32'h1, 32'h0, TO);
        drain(1, 1'b0);

        // Response backpressure fills the FIFO
        i_rsp_ready = 1'b0; full_seen = 1'b0;
        for (int i = 0; i < 6; i++)
            push(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3));
        repeat (20) tick();
        check("bp_cmd_ready_low", 32'(o_cmd_ready), 32'(0));
        check("bp_full_seen", 32'(full_seen), 32'(1));
        check("bp_no_rsp", 32'(act_q.size()), 32'(0));
        check("bp_busy", 32'(o_busy), 32'(1));
        drain(6, 1'b1);

        // Reset pulse mid-REQUEST with commands queued
        for (int i = 0; i < 3; i++) push(1'b0, 32'(i), 32'h0, 1000);
        check("rr_req_high", 32'(o_bus_request), 32'(1));
        i_reset = 1'b1;
        tick();
        check("rr_req_drop", 32'(o_bus_request), 32'(0));
        i_reset = 1'b0;
        exp_q.delete(); dly_q.delete();
        repeat (20) tick();
        bus_q.delete();
        check("rr_no_rsp", 32'(act_q.size()), 32'(0));
        check("rr_busy", 32'(o_busy), 32'(0));
        check("rr_cmd_ready", 32'(o_cmd_ready), 32'(1));
        check("rr_req_idle", 32'(o_bus_request), 32'(0));

        // Random mix of reads, writes, delays and timeouts
        for (int i = 0; i < 12; i++)
            push(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)), $urandom, $urandom_range(0, TO + 2));
        drain(12, 1'b1);
        repeat (3) tick();
        check("end_busy", 32'(o_busy), 32'(0));
        check("end_cmd_ready", 32'(o_cmd_ready), 32'(1));
        check("end_exp_empty", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
